mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the core's single memory bus between instruction fetch (F stage) and load/store (M stage). It grants one requester at a time, with data always winning over fetch, and runs exactly one bus transaction to completion before granting again. Its `i_ready`/`d_ready` outputs drive the pipeline's stall logic: fetch stalls while `i_ready` is low, and M stalls while `d_ready` is low. A response timeout turns a hung bus into an error pulse instead of a deadlock.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles waited in RESP for `m_rvalid` before a timeout error; must be ≥1.
- `clk` in 1: core clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request; held until `i_ready` or until killed.
- `i_addr` in 32: fetch address; stable while `i_req` is high.
- `i_kill` in 1: discards the in-flight or pending fetch (branch taken in E).
- `i_rdata` out 32: fetched instruction; valid when `i_ready` is high.
- `i_ready` out 1: one-cycle fetch completion pulse.
- `d_req` in 1: data request; held until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: byte enables.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data; valid when `d_ready` is high.
- `d_ready` out 1: one-cycle data completion pulse.
- `d_err` / `i_err` out 1: pulse coincident with `d_ready` / `i_ready` when the transaction timed out.
- `m_valid` out 1: bus command valid.
- `m_ready` in 1: bus accepts the command.
- `m_we`, `m_be`, `m_addr`, `m_wdata` out 1/4/32/32: command fields; registered at grant.
- `m_rvalid` in 1: bus response; loads and stores each get exactly one.
- `m_rdata` in 32: response data.

## Operation
- States are IDLE, ADDR, RESP, and DONE (DONE exists only with the configuration macro).
- **IDLE:**
  - If `d_req` is high, grant data.
  - Otherwise, if `i_req` is high and `i_kill` is low, grant fetch.
  - A grant latches the owner and the command fields and moves to ADDR.
- **ADDR:**
  - `m_valid` is high and the command is held stable.
  - `m_valid` and `m_ready` both high moves to RESP and clears the timeout counter.
- **RESP:**
  - The counter increments each cycle without `m_rvalid`.
  - `m_rvalid` completes the transaction.
  - Counter == `TIMEOUT_CYCLES`-1 with no `m_rvalid` completes it with err=1 and rdata=0.
- **Completion:**
  - The owner's ready pulses, plus err if the transaction timed out; the other ready stays low.
  - The next state is IDLE.
- **Kill:**
  - `i_kill` in ADDR or RESP while fetch owns the bus sets a sticky `killed` flag.
  - The transaction still finishes on the bus. At completion `i_ready`/`i_err` stay suppressed; the flag clears on return to IDLE.
  - `i_kill` in IDLE blocks the fetch grant that cycle.
- A `d_req` that arrives while fetch owns the bus waits; it is never preemptive.
- A late `m_rvalid` after a timeout is ignored in IDLE. The external bus must not produce one.
- **Reset (asserted at any time, including mid-transaction):**
  - State returns to IDLE; owner, `killed` and the counter clear.
  - All outputs go to 0: `m_valid`, `m_*` fields, `i_ready`, `d_ready`, `i_err`, `d_err`, `i_rdata`, `d_rdata`.

## Timing
- Zero-wait bus (`m_ready` is 1 in ADDR, `m_rvalid` is 1 in the first RESP cycle):
  - Request sampled in cycle 0.
  - `m_valid` in cycle 1.
  - Ready pulse in cycle 2 (combinational from `m_rvalid`).
  - Earliest next grant in cycle 3; the next `m_valid` in cycle 4.
- Steady-state throughput is therefore one transaction per 3 cycles.
- The ready pulse lasts exactly one cycle. The requester drops or changes its request in the following cycle; a still-high `d_req` is treated as a new request.
- A timeout ready pulse fires `TIMEOUT_CYCLES` cycles after entering RESP.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates, never wraps.

## Configuration
- `MEM_ARB_RDATA_REG_EN` defined:
  - `m_rdata` and the completion are registered into a DONE state.
  - Ready, err and rdata are all driven from flops, one cycle later (zero-wait ready lands in cycle 3; next grant in cycle 4).
  - `i_kill` in DONE also suppresses `i_ready`.
- Not defined: there is no DONE state, and ready/rdata are combinational from `m_rvalid`/`m_rdata`.

## Structure
- Package `mem_arb_pkg` holds:
  - `mem_arb_state_t` (IDLE, ADDR, RESP, DONE).
  - `mem_arb_owner_t` (OWN_I, OWN_D).
  - `MEM_BUS_AW` = 32 and `MEM_BUS_DW` = 32.
- One sub-module, `mem_arb_timeout`: a clear/enable saturating counter that outputs `expired`, parameterized on `TIMEOUT_CYCLES`.

## Test plan
- Fetch only, zero-wait bus, `i_addr`=0x100, `m_rdata`=0x00500093 -> `m_valid` in cycle 1, then `i_ready`=1 with `i_rdata`=0x00500093 in cycle 2 (cycle 3 with the macro).
- `i_req` and `d_req` asserted in the same cycle, store `d_addr`=0x2000, `d_be`=0xF -> `m_we`=1 with `m_addr`=0x2000 first; `i_ready` comes only after a second transaction (≥3 cycles after `d_ready`).
- Load while `m_ready` is held low for 5 cycles -> `m_valid` and `m_addr` stay stable all 5 cycles; RESP is entered only on the handshake.
- Fetch in flight, `i_kill` pulsed in RESP, `m_rvalid` arrives 3 cycles later -> no `i_ready`; IDLE follows, and a new `i_req` is granted.
- `TIMEOUT_CYCLES`=4, `m_rvalid` never asserted on a load -> `d_ready`=1, `d_err`=1, `d_rdata`=0 exactly 4 cycles after entering RESP.
- `reset_n` pulled low during RESP -> IDLE and all outputs 0 asynchronously; after release, a pending `d_req` is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and bus widths for the memory arbiter.
// Optional feature macro used by mem_arbiter: MEM_ARB_RDATA_REG_EN.
package mem_arb_pkg;

  localparam int unsigned MEM_BUS_AW = 32;
  localparam int unsigned MEM_BUS_DW = 32;
  localparam int unsigned MEM_BUS_BW = MEM_BUS_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } mem_arb_owner_t;

  // Command fields captured at grant and held on the bus until the handshake.
  typedef struct packed {
    logic                  we;
    logic [MEM_BUS_BW-1:0] be;
    logic [MEM_BUS_AW-1:0] addr;
    logic [MEM_BUS_DW-1:0] wdata;
  } mem_arb_cmd_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating response-wait counter with synchronous clear and count enable.
// o_expired is high while the count equals TIMEOUT_CYCLES-1.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count waiting cycles; hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_EXP);

endmodule

// File: rtl/mem_arbiter.sv
// Single-bus arbiter between instruction fetch and load/store; data has
// priority, one transaction runs to completion before the next grant, and a
// response timeout completes a hung transaction with an error pulse.
// Optional feature macro: MEM_ARB_RDATA_REG_EN registers the completion into
// a DONE state so ready/err/rdata come from flops one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // Fetch port
  input  logic                  i_req,
  input  logic [MEM_BUS_AW-1:0] i_addr,
  input  logic                  i_kill,
  output logic [MEM_BUS_DW-1:0] i_rdata,
  output logic                  i_ready,
  output logic                  i_err,
  // Data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [MEM_BUS_BW-1:0] d_be,
  input  logic [MEM_BUS_AW-1:0] d_addr,
  input  logic [MEM_BUS_DW-1:0] d_wdata,
  output logic [MEM_BUS_DW-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_err,
  // Memory bus
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_we,
  output logic [MEM_BUS_BW-1:0] m_be,
  output logic [MEM_BUS_AW-1:0] m_addr,
  output logic [MEM_BUS_DW-1:0] m_wdata,
  input  logic                  m_rvalid,
  input  logic [MEM_BUS_DW-1:0] m_rdata
);

  mem_arb_state_t r_state, w_state_nxt;
  mem_arb_owner_t r_owner, w_owner_nxt;
  mem_arb_cmd_t   r_cmd,   w_cmd_nxt;
  logic           r_killed, w_killed_nxt;

  logic                  w_tmo_clr;
  logic                  w_tmo_en;
  logic                  w_expired;
  logic                  w_timed_out;
  logic                  w_resp_done;
  logic                  w_fin;
  logic                  w_fin_err;
  logic [MEM_BUS_DW-1:0] w_fin_rdata;
  logic                  w_i_live;

  // A real response always wins over an expiry in the same cycle.
  assign w_timed_out = (r_state == RESP) && !m_rvalid && w_expired;
  assign w_resp_done = (r_state == RESP) && (m_rvalid || w_expired);
  assign w_tmo_en    = (r_state == RESP) && !m_rvalid;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expired(w_expired)
  );

  // Next-state, grant selection and kill tracking.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_cmd_nxt    = r_cmd;
    w_killed_nxt = r_killed;
    w_tmo_clr    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_killed_nxt = 1'b0;
        if (d_req) begin
          w_owner_nxt = OWN_D;
          w_cmd_nxt   = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
          w_state_nxt = ADDR;
        end else if (i_req && !i_kill) begin
          w_owner_nxt = OWN_I;
          w_cmd_nxt   = '{we: 1'b0, be: {MEM_BUS_BW{1'b1}}, addr: i_addr, wdata: '0};
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (m_ready) begin
          w_tmo_clr   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (w_resp_done) begin
`ifdef MEM_ARB_RDATA_REG_EN
          w_state_nxt = DONE;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // A branch kill while fetch owns the bus poisons the eventual completion.
    if ((r_state != IDLE) && (r_owner == OWN_I) && i_kill) begin
      w_killed_nxt = 1'b1;
    end
  end

  // State, owner, kill flag and latched command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_owner  <= OWN_I;
      r_cmd    <= '0;
      r_killed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_cmd    <= w_cmd_nxt;
      r_killed <= w_killed_nxt;
    end
  end

`ifdef MEM_ARB_RDATA_REG_EN
  logic                  r_fin_err;
  logic [MEM_BUS_DW-1:0] r_fin_rdata;

  // Capture the completion result for presentation from DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fin_err   <= 1'b0;
      r_fin_rdata <= '0;
    end else if (w_resp_done) begin
      r_fin_err   <= w_timed_out;
      r_fin_rdata <= w_timed_out ? '0 : m_rdata;
    end
  end

  assign w_fin       = (r_state == DONE);
  assign w_fin_err   = r_fin_err;
  assign w_fin_rdata = r_fin_rdata;
`else
  assign w_fin       = w_resp_done;
  assign w_fin_err   = w_timed_out;
  assign w_fin_rdata = w_timed_out ? '0 : m_rdata;
`endif

  // A kill in the completion cycle itself also discards the fetch.
  assign w_i_live = !r_killed && !i_kill;

  assign i_ready = w_fin && (r_owner == OWN_I) && w_i_live;
  assign i_err   = i_ready && w_fin_err;
  assign i_rdata = i_ready ? w_fin_rdata : '0;

  assign d_ready = w_fin && (r_owner == OWN_D);
  assign d_err   = d_ready && w_fin_err;
  assign d_rdata = d_ready ? w_fin_rdata : '0;

  assign m_valid = (r_state == ADDR);
  assign m_we    = r_cmd.we;
  assign m_be    = r_cmd.be;
  assign m_addr  = r_cmd.addr;
  assign m_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int unsigned T = 4;
`ifdef MEM_ARB_RDATA_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0, i_kill = 1'b0, i_ready, i_err;
  logic [31:0] i_addr = '0, i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ready, d_err;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic        m_valid, m_ready = 1'b0, m_we, m_rvalid = 1'b0;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata = '0;

  mem_arbiter #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_kill  (i_kill),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .d_err   (d_err),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Requester state: a pending request is held until its ready (or a kill).
  bit          rnd_en = 1'b0;
  bit          i_pend = 1'b0, d_pend = 1'b0;
  logic [31:0] ip_addr = '0;
  logic        dp_we = 1'b0;
  logic [3:0]  dp_be = '0;
  logic [31:0] dp_addr = '0, dp_wdata = '0;

  // Directed knobs (-1 = random).
  int          f_acc = -1, f_rsp = -1, kill_at = -1;
  bit          fix_rdata_en = 1'b0;
  logic [31:0] fix_rdata = '0;

  // In-flight transaction timeline: grant at g, command visible g+1..t_h,
  // handshake at t_h, completion at t_done, ready at t_rdy = t_done + LAT.
  bit          busy = 1'b0, t_is_d = 1'b0, t_killed = 1'b0, t_err = 1'b0;
  int          t_h = 0, t_done = 0, t_rdy = 0, t_rsp = 0;
  logic        t_we = 1'b0;
  logic [3:0]  t_be = '0;
  logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;

  task automatic start_txn(input bit is_d);
    int acc;
    acc      = (f_acc >= 0) ? f_acc : (($urandom_range(1) == 0) ? 0 : int'($urandom_range(3)));
    t_rsp    = (f_rsp >= 0) ? f_rsp : (($urandom_range(5) == 0) ? 99 : int'($urandom_range(3)));
    busy     = 1'b1;
    t_is_d   = is_d;
    t_killed = 1'b0;
    t_we     = is_d ? dp_we : 1'b0;
    t_be     = dp_be;
    t_addr   = is_d ? dp_addr : ip_addr;
    t_wdata  = dp_wdata;
    t_h      = cyc + 1 + acc;
    t_err    = (t_rsp >= int'(T));
    t_done   = t_err ? t_h + int'(T) : t_h + 1 + t_rsp;
    t_rdy    = t_done + LAT;
    t_rdata  = '0;
  endtask

  task automatic step();
    logic kill;
    bit   exp_mv, rdy_now, gi;
    @(negedge clk);
    if (rnd_en) begin
      if (!d_pend && $urandom_range(3) == 0) begin
        d_pend = 1'b1; dp_we = 1'($urandom_range(1)); dp_be = 4'($urandom);
        dp_addr = $urandom; dp_wdata = $urandom;
      end
      if (!i_pend && $urandom_range(2) == 0) begin
        i_pend = 1'b1; ip_addr = $urandom & 32'hFFFF_FFFC;
      end
      kill = ($urandom_range(9) == 0);
    end else begin
      kill = (cyc == kill_at);
    end
    i_req = i_pend; i_addr = ip_addr; i_kill = kill;
    d_req = d_pend; d_we = dp_we; d_be = dp_be; d_addr = dp_addr; d_wdata = dp_wdata;
    m_rdata = fix_rdata_en ? fix_rdata : $urandom;
    if (busy) begin
      m_ready  = (cyc == t_h);
      m_rvalid = (t_rsp < int'(T)) && (cyc == t_h + 1 + t_rsp);
    end else if (rnd_en) begin
      m_ready  = 1'($urandom_range(1));
      m_rvalid = ($urandom_range(7) == 0);
    end else begin
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
    end
    if (busy && cyc == t_done && !t_err) t_rdata = m_rdata;
    if (busy && !t_is_d && kill) t_killed = 1'b1;
    #1;
    exp_mv  = busy && (cyc <= t_h);
    rdy_now = busy && (cyc == t_rdy);
    check("m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_mv) begin
      check("m_addr", m_addr, t_addr);
      check("m_we", 32'(m_we), 32'(t_we));
      if (t_is_d) begin
        check("m_be", 32'(m_be), 32'(t_be));
        check("m_wdata", m_wdata, t_wdata);
      end
    end
    check("d_ready", 32'(d_ready), 32'(rdy_now && t_is_d));
    check("d_err", 32'(d_err), 32'(rdy_now && t_is_d && t_err));
    check("i_ready", 32'(i_ready), 32'(rdy_now && !t_is_d && !t_killed));
    check("i_err", 32'(i_err), 32'(rdy_now && !t_is_d && !t_killed && t_err));
    if (rdy_now && t_is_d) check("d_rdata", d_rdata, t_rdata);
    if (rdy_now && !t_is_d && !t_killed) check("i_rdata", i_rdata, t_rdata);
    // Advance the model to the next cycle.
    gi = i_req && !kill;
    if (rdy_now) begin
      busy = 1'b0;
      if (t_is_d) d_pend = 1'b0;
      else if (!t_killed) i_pend = 1'b0;
    end else if (!busy) begin
      if (d_pend) start_txn(1'b1);
      else if (gi) start_txn(1'b0);
    end
    if (kill) i_pend = 1'b0;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || i_pend || d_pend) && n < 80) begin
      step();
      n++;
    end
    check("drain_bound", 32'(busy || i_pend || d_pend), 32'd0);
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_we"}, 32'(m_we), 32'd0);
    check({tag, "_m_be"}, 32'(m_be), 32'd0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'd0);
    check({tag, "_i_ready"}, 32'(i_ready), 32'd0);
    check({tag, "_d_ready"}, 32'(d_ready), 32'd0);
    check({tag, "_i_err"}, 32'(i_err), 32'd0);
    check({tag, "_d_err"}, 32'(d_err), 32'd0);
    check({tag, "_i_rdata"}, i_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  task automatic set_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd);
    d_pend = 1'b1; dp_we = we; dp_be = be; dp_addr = a; dp_wdata = wd;
  endtask

  initial begin
    #12;
    check_zero("reset");
    #10;
    reset_n = 1'b1;

    // Fetch only, zero-wait bus.
    fix_rdata_en = 1'b1; fix_rdata = 32'h0050_0093;
    f_acc = 0; f_rsp = 0;
    i_pend = 1'b1; ip_addr = 32'h100;
    drain();
    fix_rdata_en = 1'b0;

    // Simultaneous fetch and store: data first.
    i_pend = 1'b1; ip_addr = 32'h104;
    set_d(1'b1, 4'hF, 32'h2000, 32'hCAFE_F00D);
    drain();

    // Load with the bus stalling acceptance for 5 cycles.
    f_acc = 5; f_rsp = 1;
    set_d(1'b0, 4'h3, 32'h3000, 32'h0);
    drain();

    // Fetch killed in its first RESP cycle; response arrives 3 cycles later.
    f_acc = 0; f_rsp = 3;
    i_pend = 1'b1; ip_addr = 32'h200;
    kill_at = cyc + 2;
    drain();
    kill_at = -1;
    f_rsp = 0;
    i_pend = 1'b1; ip_addr = 32'h204;
    drain();

    // Load that never gets a response.
    f_acc = 0; f_rsp = 99;
    set_d(1'b0, 4'hF, 32'h3100, 32'h0);
    drain();

    // Reset pulled during RESP; the held load is regranted afterwards.
    f_acc = 0; f_rsp = 99;
    set_d(1'b0, 4'hF, 32'h4000, 32'h0);
    step(); step(); step();
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    busy = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    f_rsp = 0;
    drain();

    // Random traffic.
    f_acc = -1; f_rsp = -1; rnd_en = 1'b1;
    for (int k = 0; k < 3000; k++) step();
    rnd_en = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
